fetch_unit: RTL and testbench

Instruction fetch stage of the pipelined MIPS core. It owns the program counter, issues one-outstanding requests to instruction memory, and presents each fetched instruction and its PC to the IF/ID pipeline register with a valid/stall handshake. It also absorbs control-flow redirects from later stages by squashing in-flight fetches.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/fetch_skid.sv | 48 ++++
 rtl/fetch_unit.sv | 159 +++++++++++++++
 tb/tb_fetch_unit.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared types and constants for the MIPS fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

`default_nettype wire

// File: rtl/fetch_skid.sv
// ============================================================================
// Module   : fetch_skid
// Brief    : One-entry {pc, instr} buffer behind the IF/ID output register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_skid (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  logic [31:0] push_pc,
    input  logic [31:0] push_instr,
    output logic        full,
    output logic [31:0] pc,
    output logic [31:0] instr
);

    logic        r_full;
    logic [31:0] r_pc;
    logic [31:0] r_instr;

    // A push in the same cycle as a pop refills the entry with the new word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_full  <= 1'b0;
            r_pc    <= 32'h0;
            r_instr <= 32'h0;
        end else if (flush) begin
            r_full <= 1'b0;
        end else if (push) begin
            r_full  <= 1'b1;
            r_pc    <= push_pc;
            r_instr <= push_instr;
        end else if (pop) begin
            r_full <= 1'b0;
        end
    end

    assign full  = r_full;
    assign pc    = r_pc;
    assign instr = r_instr;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction fetch stage: PC, one-outstanding imem requests,
//            IF/ID valid/stall handshake and redirect squashing.
//            Define FETCH_PERF_CNT_EN to add fetch_count/stall_count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] IR,
    output logic [31:0] pc_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    fetch_state_t r_state, w_state_nxt;
    logic [31:0]  r_pc, w_pc_nxt;
    logic         r_if_valid, w_valid_nxt;
    logic [31:0]  r_ir, w_ir_nxt;
    logic [31:0]  r_pc_out, w_pc_out_nxt;

    logic         w_skid_push, w_skid_pop, w_skid_flush, w_skid_full;
    logic [31:0]  w_skid_pc, w_skid_instr;
    logic         w_out_free, w_req, w_data_in;

    assign w_out_free = !r_if_valid || !stall;
    // Holding off new requests while the skid is occupied keeps at most one
    // word buffered behind a stalled output register.
    assign w_req      = (r_state == REQ) && !w_skid_full;
    assign w_data_in  = (r_state == WAIT) && imem_rvalid;

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_valid_nxt  = r_if_valid;
        w_ir_nxt     = r_ir;
        w_pc_out_nxt = r_pc_out;
        w_skid_push  = 1'b0;
        w_skid_pop   = 1'b0;
        w_skid_flush = 1'b0;

        if (redirect_valid) begin
            w_pc_nxt     = redirect_pc & ~32'd3;
            w_skid_flush = 1'b1;
            w_valid_nxt  = 1'b0;
            w_ir_nxt     = NOP_INSTR;
            case (r_state)
                IDLE:    w_state_nxt = REQ;
                REQ:     w_state_nxt = (w_req && imem_gnt) ? DROP : REQ;
                WAIT:    w_state_nxt = imem_rvalid ? REQ : DROP;
                // A response landing now retires the stale request.
                DROP:    w_state_nxt = imem_rvalid ? REQ : DROP;
                default: w_state_nxt = IDLE;
            endcase
        end else begin
            case (r_state)
                IDLE: w_state_nxt = REQ;
                REQ:  if (w_req && imem_gnt) w_state_nxt = WAIT;
                WAIT: if (imem_rvalid) begin
                    w_state_nxt = REQ;
                    w_pc_nxt    = r_pc + INSTR_BYTES;
                end
                DROP: if (imem_rvalid) w_state_nxt = REQ;
                default: w_state_nxt = IDLE;
            endcase

            if (w_out_free) begin
                if (w_skid_full) begin
                    w_valid_nxt  = 1'b1;
                    w_ir_nxt     = w_skid_instr;
                    w_pc_out_nxt = w_skid_pc;
                    w_skid_pop   = 1'b1;
                end else if (w_data_in) begin
                    w_valid_nxt  = 1'b1;
                    w_ir_nxt     = imem_rdata;
                    w_pc_out_nxt = r_pc;
                end else begin
                    w_valid_nxt  = 1'b0;
                    w_ir_nxt     = NOP_INSTR;
                end
            end
            w_skid_push = w_data_in && (!w_out_free || w_skid_full);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_if_valid <= 1'b0;
            r_ir       <= NOP_INSTR;
            r_pc_out   <= 32'h0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_if_valid <= w_valid_nxt;
            r_ir       <= w_ir_nxt;
            r_pc_out   <= w_pc_out_nxt;
        end
    end

    fetch_skid u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (w_skid_push),
        .pop        (w_skid_pop),
        .flush      (w_skid_flush),
        .push_pc    (r_pc),
        .push_instr (imem_rdata),
        .full       (w_skid_full),
        .pc         (w_skid_pc),
        .instr      (w_skid_instr)
    );

    assign imem_req  = w_req;
    assign imem_addr = r_pc;
    assign if_valid  = r_if_valid;
    assign IR        = r_ir;
    assign pc_out    = r_pc_out;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_count, r_stall_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_count <= 32'h0;
            r_stall_count <= 32'h0;
        end else begin
            if (r_if_valid && !stall) r_fetch_count <= r_fetch_count + 32'd1;
            if (r_if_valid && stall)  r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign fetch_count = r_fetch_count;
    assign stall_count = r_stall_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Self-checking bench for fetch_unit (FETCH_PERF_CNT_EN optional).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    localparam logic [31:0] MASK = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n, stall, redirect_valid, imem_req, imem_gnt, imem_rvalid, if_valid;
    logic [31:0] redirect_pc, imem_addr, imem_rdata, IR, pc_out;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count, stall_count;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .IR             (IR),
        .pc_out         (pc_out)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count    (fetch_count),
        .stall_count    (stall_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Program-order model: the next instruction handed downstream.
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] exp_fc = 32'h0, exp_sc = 32'h0;
    int          redir_age = 100;
    int          consumed = 0;

    // What the DUT saw at the upcoming edge.
    bit          p_rst = 1'b0, p_stall = 1'b0, p_redir = 1'b0;
    logic        p_valid = 1'b0;
    logic [31:0] p_target = 32'h0;

    // Memory responder state.
    bit          outst = 1'b0, gnt_always = 1'b1, mem_freeze = 1'b0, gnt_seen = 1'b0;
    int          cnt = 0, lat_fix = 1;
    logic [31:0] maddr = 32'h0, first_gnt_addr = 32'h0;

    // Test controls.
    bit          rst_req = 1'b0, stall_req = 1'b0, rand_stall = 1'b0, redir_req = 1'b0;
    logic [31:0] redir_tgt = 32'h0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (!p_rst) begin
            exp_pc    = 32'h0;
            exp_fc    = 32'h0;
            exp_sc    = 32'h0;
            redir_age = 100;
        end else begin
            if (p_valid === 1'b1) begin
                if (p_stall) exp_sc = exp_sc + 32'd1;
                else         exp_fc = exp_fc + 32'd1;
            end
            if (p_redir) begin
                exp_pc    = p_target & ~32'd3;
                redir_age = 0;
            end else begin
                if (p_valid === 1'b1 && !p_stall) begin
                    exp_pc = exp_pc + 32'd4;
                    consumed++;
                end
                if (redir_age < 100) redir_age++;
            end
        end
        if (if_valid === 1'b1) begin
            chk32("pc_out", pc_out, exp_pc);
            chk32("IR", IR, exp_pc ^ MASK);
        end else begin
            chk1("if_valid_known", if_valid, 1'b0);
            chk32("IR_nop", IR, 32'h0);
        end
        if (redir_age <= 1) chk1("redirect_squash", if_valid, 1'b0);
        if (imem_req === 1'b1) begin
            chk32("addr_align", {30'h0, imem_addr[1:0]}, 32'h0);
            chk1("one_outstanding", outst, 1'b0);
        end
`ifdef FETCH_PERF_CNT_EN
        chk32("fetch_count", fetch_count, exp_fc);
        chk32("stall_count", stall_count, exp_sc);
`endif
    endtask

    task automatic drive();
        rst_n          = rst_req;
        stall          = rand_stall ? ($urandom % 4 == 0) : stall_req;
        redirect_valid = redir_req;
        redirect_pc    = redir_tgt;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = $urandom;
        if (!mem_freeze) begin
            if (outst) begin
                if (cnt <= 1) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = maddr ^ MASK;
                    outst       = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (imem_req === 1'b1 && (gnt_always || $urandom_range(0, 2) != 0)) begin
                imem_gnt = 1'b1;
                outst    = 1'b1;
                maddr    = imem_addr;
                cnt      = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 4));
                if (!gnt_seen) begin
                    gnt_seen       = 1'b1;
                    first_gnt_addr = imem_addr;
                end
            end
        end
        p_rst    = rst_n;
        p_valid  = if_valid;
        p_stall  = stall;
        p_redir  = redirect_valid;
        p_target = redirect_pc;
    endtask

    task automatic step();
        drive();
        tick();
    endtask

    task automatic redirect_to(input logic [31:0] tgt);
        redir_req = 1'b1;
        redir_tgt = tgt;
        drive();
        redir_req = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int start;

        // Reset state
        repeat (3) step();
        chk1("rst_req", imem_req, 1'b0);
        chk32("rst_addr", imem_addr, 32'h0);
        chk1("rst_valid", if_valid, 1'b0);
        chk32("rst_ir", IR, 32'h0);
        chk32("rst_pc_out", pc_out, 32'h0);

        // Free run, 1-cycle memory
        rst_req = 1'b1;
        step();
        chk1("first_req", imem_req, 1'b1);
        chk32("first_addr", imem_addr, 32'h0);
        step();
        chk1("wait_noreq", imem_req, 1'b0);
        chk1("wait_novalid", if_valid, 1'b0);
        step();
        chk1("first_valid", if_valid, 1'b1);
        chk32("first_pc", pc_out, 32'h0);
        chk32("first_ir", IR, 32'hA5A5_0000);
        chk1("second_req", imem_req, 1'b1);
        chk32("second_addr", imem_addr, 32'h4);
        step();
        step();
        chk32("pc4", pc_out, 32'h4);
        chk32("ir4", IR, 32'hA5A5_0004);
        repeat (10) step();

        // Stall with skid at 0x100
        redirect_to(32'h100);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (if_valid === 1'b1 && pc_out == 32'h100) begin found = 1'b1; break; end
            step();
        end
        chk1("reach_100", found, 1'b1);
        stall_req = 1'b1;
        repeat (5) step();
        chk32("stall_pc", pc_out, 32'h100);
        chk32("stall_ir", IR, 32'h100 ^ MASK);
        chk1("skid_full_noreq", imem_req, 1'b0);
        stall_req = 1'b0;
        step();
        chk1("skid_valid", if_valid, 1'b1);
        chk32("skid_pc", pc_out, 32'h104);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (if_valid === 1'b1) begin found = 1'b1; break; end
        end
        chk1("after_skid_valid", found, 1'b1);
        chk32("after_skid_pc", pc_out, 32'h108);

        // Redirect during WAIT with 3-cycle memory
        lat_fix = 3;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (outst && cnt == 3) begin found = 1'b1; break; end
            step();
        end
        chk1("reach_wait3", found, 1'b1);
        gnt_seen = 1'b0;
        redirect_to(32'h2002);
        for (int i = 0; i < 20 && !gnt_seen; i++) step();
        chk1("drop_gnt_seen", gnt_seen, 1'b1);
        chk32("drop_next_addr", first_gnt_addr, 32'h2000);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (if_valid === 1'b1) begin found = 1'b1; break; end
            step();
        end
        chk1("drop_valid", found, 1'b1);
        chk32("drop_first_pc", pc_out, 32'h2000);

        // Redirect on the rvalid cycle
        lat_fix = 1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (outst && cnt == 1) begin found = 1'b1; break; end
            step();
        end
        chk1("reach_rvalid", found, 1'b1);
        redirect_to(32'h3000);
        chk1("rv_redir_req", imem_req, 1'b1);
        chk32("rv_redir_addr", imem_addr, 32'h3000);
        chk1("rv_redir_valid", if_valid, 1'b0);
        repeat (8) step();

        // PC wrap
        redirect_to(32'hFFFF_FFFC);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (if_valid === 1'b1 && pc_out == 32'hFFFF_FFFC) begin found = 1'b1; break; end
            step();
        end
        chk1("reach_wrap", found, 1'b1);
        chk1("wrap_req", imem_req, 1'b1);
        chk32("wrap_addr", imem_addr, 32'h0);
        repeat (8) step();

        // Reset pulse during WAIT, late response afterwards
        lat_fix = 3;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (outst && cnt == 3) begin found = 1'b1; break; end
            step();
        end
        chk1("reach_wait_rst", found, 1'b1);
        rst_req    = 1'b0;
        mem_freeze = 1'b1;
        step();
        chk1("mrst_valid", if_valid, 1'b0);
        chk1("mrst_req", imem_req, 1'b0);
        chk32("mrst_addr", imem_addr, 32'h0);
        chk32("mrst_pc_out", pc_out, 32'h0);
        rst_req    = 1'b1;
        mem_freeze = 1'b0;
        cnt        = 1;
        step();
        chk1("late_rv_valid", if_valid, 1'b0);
        chk1("restart_req", imem_req, 1'b1);
        chk32("restart_addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk32("mrst_fetch_count", fetch_count, 32'h0);
        chk32("mrst_stall_count", stall_count, 32'h0);
`endif
        repeat (10) step();

        // Randomized traffic
        rand_stall = 1'b1;
        gnt_always = 1'b0;
        lat_fix    = 0;
        start      = consumed;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom % 30 == 0) begin
                redir_req = 1'b1;
                redir_tgt = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
            end
            drive();
            redir_req = 1'b0;
            tick();
        end
        chk1("progress", (consumed - start) > 200, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
